// File: rtl/btb_update_ctrl.sv
// BTB update sequencer: queues resolved branches from Execute, issues one BTB
// write command per cycle in resolution order, and raises fetch redirects on mispredicts.
module btb_update_ctrl #(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [31:0]               res_pc,
    input  logic [31:0]               res_target,
    input  logic                      res_taken,
    input  logic                      res_hit,
    input  logic [31:0]               res_pred_pc,
    input  logic                      upd_hold,
    output logic                      btb_write,
    output logic                      state_write,
    output logic                      state_change,
    output logic                      branch_e,
    output logic [31:0]               branch_address_in,
    output logic [31:0]               predicted_address_in,
    output logic                      redirect_valid,
    output logic [31:0]               redirect_pc,
    output logic [$clog2(QDEPTH):0]   q_count,
    input  logic                      clear_stats,
    output logic [CNT_W-1:0]          branch_count,
    output logic [CNT_W-1:0]          mispredict_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [31:0]       r_fifo_pc    [QDEPTH];
    logic [31:0]       r_fifo_tgt   [QDEPTH];
    logic              r_fifo_taken [QDEPTH];
    logic              r_fifo_hit   [QDEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic [31:0]       r_cmd_pc;
    logic [31:0]       r_cmd_tgt;
    logic              r_cmd_taken;
    logic              r_cmd_hit;

    logic              r_redirect_valid;
    logic [31:0]       r_redirect_pc;
    logic [CNT_W-1:0]  r_branch_count;
    logic [CNT_W-1:0]  r_mispredict_count;

    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_seq_pc;
    logic [31:0]       w_actual_pc;
    logic [31:0]       w_fetch_pc;
    logic              w_mispredict;

    assign res_ready    = (r_count < CW'(QDEPTH));
    assign w_push       = res_valid & res_ready;
    assign w_pop        = (r_count != '0) & ~upd_hold;

    assign w_seq_pc     = res_pc + 32'd4;
    assign w_actual_pc  = res_taken ? res_target : w_seq_pc;
    assign w_fetch_pc   = res_hit ? res_pred_pc : w_seq_pc;
    assign w_mispredict = (w_actual_pc != w_fetch_pc);

    assign q_count          = r_count;
    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

    // Storage needs no reset: occupancy and pointers decide what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]    <= res_pc;
            r_fifo_tgt[r_wptr]   <= res_target;
            r_fifo_taken[r_wptr] <= res_taken;
            r_fifo_hit[r_wptr]   <= res_hit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_pc    <= '0;
            r_cmd_tgt   <= '0;
            r_cmd_taken <= 1'b0;
            r_cmd_hit   <= 1'b0;
        end else if (w_pop) begin
            r_cmd_pc    <= r_fifo_pc[r_rptr];
            r_cmd_tgt   <= r_fifo_tgt[r_rptr];
            r_cmd_taken <= r_fifo_taken[r_rptr];
            r_cmd_hit   <= r_fifo_hit[r_rptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Every pop yields exactly one ISSUE cycle, so back-to-back pops stay in ISSUE.
    always_comb begin
        w_next_state = IDLE;
        if (w_pop) w_next_state = ISSUE;
    end

    always_comb begin
        btb_write            = 1'b0;
        state_write          = 1'b0;
        state_change         = 1'b0;
        branch_e             = 1'b0;
        branch_address_in    = '0;
        predicted_address_in = '0;
        if (r_state == ISSUE) begin
            btb_write            = ~r_cmd_hit & r_cmd_taken;
            state_write          = r_cmd_hit;
            state_change         = r_cmd_taken;
            branch_e             = 1'b1;
            branch_address_in    = r_cmd_pc;
            predicted_address_in = r_cmd_tgt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_push & w_mispredict;
            if (w_push) r_redirect_pc <= w_actual_pc;
        end
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (clear_stats) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_push && (r_branch_count != '1))
                r_branch_count <= r_branch_count + 1'b1;
            if (w_push && w_mispredict && (r_mispredict_count != '1))
                r_mispredict_count <= r_mispredict_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl with hand-computed expectations,
// using a 4-bit counter width so saturation is reachable quickly.
module tb_btb_update_ctrl;

    localparam int QDEPTH = 4;
    localparam int CNT_W  = 4;

    logic        clk;
    logic        reset;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_taken;
    logic        res_hit;
    logic [31:0] res_pred_pc;
    logic        upd_hold;
    logic        btb_write;
    logic        state_write;
    logic        state_change;
    logic        branch_e;
    logic [31:0] branch_address_in;
    logic [31:0] predicted_address_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  q_count;
    logic        clear_stats;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    int compareCount;
    int mismatchCount;

    btb_update_ctrl #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_target(res_target), .res_taken(res_taken),
        .res_hit(res_hit), .res_pred_pc(res_pred_pc), .upd_hold(upd_hold),
        .btb_write(btb_write), .state_write(state_write),
        .state_change(state_change), .branch_e(branch_e),
        .branch_address_in(branch_address_in),
        .predicted_address_in(predicted_address_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .q_count(q_count), .clear_stats(clear_stats),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic [31:0] tgt, input logic taken,
                                 input logic hit, input logic [31:0] pred);
        res_valid   = valid;
        res_pc      = pc;
        res_target  = tgt;
        res_taken   = taken;
        res_hit     = hit;
        res_pred_pc = pred;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] hpc [5];
        logic [31:0] htgt[5];
        logic        htk [5];

        compareCount  = 0;
        mismatchCount = 0;
        reset       = 1'b0;
        upd_hold    = 1'b0;
        clear_stats = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        #3;
        checkOutput("rst_ready", {31'd0, res_ready}, 32'd1);
        checkOutput("rst_qcount", {29'd0, q_count}, 32'd0);
        checkOutput("rst_branch_e", {31'd0, branch_e}, 32'd0);
        checkOutput("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
        checkOutput("rst_branch_count", {28'd0, branch_count}, 32'd0);
        #10 reset = 1'b1;
        stepCycle();

        // Unknown taken branch: mispredict, then btb_write one cycle later
        applyStimulus(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        checkOutput("t1_redirect_pc", redirect_pc, 32'h80);
        checkOutput("t1_qcount", {29'd0, q_count}, 32'd1);
        checkOutput("t1_no_cmd_yet", {31'd0, branch_e}, 32'd0);
        checkOutput("t1_branch_count", {28'd0, branch_count}, 32'd1);
        checkOutput("t1_mispredict_count", {28'd0, mispredict_count}, 32'd1);
        stepCycle();
        checkOutput("t1_btb_write", {31'd0, btb_write}, 32'd1);
        checkOutput("t1_state_write", {31'd0, state_write}, 32'd0);
        checkOutput("t1_branch_e", {31'd0, branch_e}, 32'd1);
        checkOutput("t1_state_change", {31'd0, state_change}, 32'd1);
        checkOutput("t1_branch_addr", branch_address_in, 32'h40);
        checkOutput("t1_pred_addr", predicted_address_in, 32'h80);
        checkOutput("t1_redirect_drop", {31'd0, redirect_valid}, 32'd0);
        stepCycle();
        checkOutput("t1_cmd_done", {31'd0, branch_e}, 32'd0);

        // Hit predicted taken but actually not taken
        applyStimulus(1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 32'h200);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        checkOutput("t2_redirect_pc", redirect_pc, 32'h104);
        checkOutput("t2_mispredict_count", {28'd0, mispredict_count}, 32'd2);
        stepCycle();
        checkOutput("t2_state_write", {31'd0, state_write}, 32'd1);
        checkOutput("t2_state_change", {31'd0, state_change}, 32'd0);
        checkOutput("t2_btb_write", {31'd0, btb_write}, 32'd0);
        checkOutput("t2_branch_addr", branch_address_in, 32'h100);

        // Correctly predicted taken hit
        applyStimulus(1'b1, 32'h180, 32'h200, 1'b1, 1'b1, 32'h200);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t3_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("t3_redirect_pc", redirect_pc, 32'h200);
        checkOutput("t3_mispredict_count", {28'd0, mispredict_count}, 32'd2);
        checkOutput("t3_branch_count", {28'd0, branch_count}, 32'd3);
        stepCycle();
        checkOutput("t3_state_write", {31'd0, state_write}, 32'd1);
        checkOutput("t3_state_change", {31'd0, state_change}, 32'd1);
        checkOutput("t3_btb_write", {31'd0, btb_write}, 32'd0);

        // Unknown not-taken branch: no write command, history still advances
        applyStimulus(1'b1, 32'h500, 32'h600, 1'b0, 1'b0, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t4_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("t4_redirect_pc", redirect_pc, 32'h504);
        stepCycle();
        checkOutput("t4_branch_e", {31'd0, branch_e}, 32'd1);
        checkOutput("t4_btb_write", {31'd0, btb_write}, 32'd0);
        checkOutput("t4_state_write", {31'd0, state_write}, 32'd0);
        checkOutput("t4_pred_addr", predicted_address_in, 32'h600);
        stepCycle();

        // Hold draining while five branches arrive; fifth waits for space
        for (int i = 0; i < 5; i++) begin
            hpc[i]  = 32'h1000 + 32'(16 * i);
            htgt[i] = 32'h2000 + 32'(16 * i);
            htk[i]  = (i % 2 == 0);
        end
        upd_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, hpc[i], htgt[i], htk[i], 1'b0, 32'h0);
            stepCycle();
            checkOutput($sformatf("hold_qcount%0d", i), {29'd0, q_count}, 32'(i + 1));
            checkOutput($sformatf("hold_no_cmd%0d", i), {31'd0, branch_e}, 32'd0);
        end
        applyStimulus(1'b1, hpc[4], htgt[4], htk[4], 1'b0, 32'h0);
        checkOutput("hold_full_ready", {31'd0, res_ready}, 32'd0);
        stepCycle();
        checkOutput("hold_full_qcount", {29'd0, q_count}, 32'd4);
        upd_hold = 1'b0;
        stepCycle();
        checkOutput("drain0_addr", branch_address_in, hpc[0]);
        checkOutput("drain0_btb_write", {31'd0, btb_write}, {31'd0, htk[0]});
        checkOutput("drain0_qcount", {29'd0, q_count}, 32'd3);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("drain1_addr", branch_address_in, hpc[1]);
        checkOutput("drain1_btb_write", {31'd0, btb_write}, {31'd0, htk[1]});
        checkOutput("drain1_qcount", {29'd0, q_count}, 32'd3);
        for (int i = 2; i < 5; i++) begin
            stepCycle();
            checkOutput($sformatf("drain%0d_branch_e", i), {31'd0, branch_e}, 32'd1);
            checkOutput($sformatf("drain%0d_addr", i), branch_address_in, hpc[i]);
            checkOutput($sformatf("drain%0d_tgt", i), predicted_address_in, htgt[i]);
            checkOutput($sformatf("drain%0d_btb_write", i), {31'd0, btb_write}, {31'd0, htk[i]});
            checkOutput($sformatf("drain%0d_qcount", i), {29'd0, q_count}, 32'(4 - i));
        end
        stepCycle();
        checkOutput("drain_done", {31'd0, branch_e}, 32'd0);

        // Reset in the middle of an ISSUE with three entries still queued
        upd_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, hpc[i], htgt[i], 1'b1, 1'b0, 32'h0);
            stepCycle();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        upd_hold = 1'b0;
        stepCycle();
        checkOutput("prerst_branch_e", {31'd0, branch_e}, 32'd1);
        checkOutput("prerst_qcount", {29'd0, q_count}, 32'd3);
        reset = 1'b0;
        #1;
        checkOutput("midrst_branch_e", {31'd0, branch_e}, 32'd0);
        checkOutput("midrst_btb_write", {31'd0, btb_write}, 32'd0);
        checkOutput("midrst_qcount", {29'd0, q_count}, 32'd0);
        checkOutput("midrst_ready", {31'd0, res_ready}, 32'd1);
        checkOutput("midrst_branch_addr", branch_address_in, 32'd0);
        checkOutput("midrst_redirect_pc", redirect_pc, 32'd0);
        checkOutput("midrst_branch_count", {28'd0, branch_count}, 32'd0);
        #3 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput($sformatf("postrst_idle%0d", i), {31'd0, branch_e}, 32'd0);
        end

        // Counter saturation with correctly predicted not-hit fall-through branches
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 32'h0, 32'h4, 1'b1, 1'b0, 32'h0);
            stepCycle();
            if (i == 14)
                checkOutput("sat_at15", {28'd0, branch_count}, 32'd15);
        end
        checkOutput("sat_held", {28'd0, branch_count}, 32'd15);
        checkOutput("sat_no_mispredict", {28'd0, mispredict_count}, 32'd0);
        clear_stats = 1'b1;
        stepCycle();
        clear_stats = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("clear_beats_inc", {28'd0, branch_count}, 32'd0);
        stepCycle();
        stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Sequences writes into the branch target buffer from resolved branches in the Execute stage.
- Accepts one resolved branch per cycle into a small FIFO and drains one BTB update per cycle. Each drained entry produces exactly one write command: btb_write, state_write, or neither, plus branch_e.
- Detects mispredictions at accept time and drives a registered fetch redirect.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
QDEPTH, 4, update FIFO depth (power of two, ≥2)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
res_valid  in  1  resolved branch present in Execute
res_ready  out  1  FIFO can accept this cycle
res_pc  in  32  branch instruction address
res_target  in  32  computed branch target
res_taken  in  1  actual outcome, 1 = taken
res_hit  in  1  branch was found in BTB at fetch
res_pred_pc  in  32  PC predicted at fetch (valid when res_hit)
upd_hold  in  1  stall draining (BTB port reserved)
btb_write  out  1  allocate new BTB entry
state_write  out  1  update existing entry's prediction state
state_change  out  1  outcome for state/global history, 1 = taken
branch_e  out  1  advance global history
branch_address_in  out  32  branch PC for update
predicted_address_in  out  32  target for update
redirect_valid  out  1  mispredict redirect pulse
redirect_pc  out  32  correct next PC
q_count  out  $clog2(QDEPTH)+1  FIFO occupancy
clear_stats  in  1  synchronous clear of counters
branch_count  out  CNT_W  resolved branches accepted
mispredict_count  out  CNT_W  mispredicts detected

Behaviour:
- Reset (reset=0, async): FIFO empty, q_count=0, res_ready=1, all command outputs 0, branch_address_in=0, predicted_address_in=0, redirect_valid=0, redirect_pc=0, both counters 0. Queued entries are discarded.
- Accept:
  - Accept occurs when res_valid & res_ready at a rising edge.
  - res_ready = (q_count < QDEPTH). Combinational from occupancy only; no pass-through when full.
  - Entry stored: {pc, target, taken, hit}.
- Actual next PC: res_taken ? res_target : res_pc+4 (32-bit wrap).
- Mispredict: the fetch-predicted PC is res_hit ? res_pred_pc : res_pc+4. A mispredict is when the actual next PC differs from the fetch-predicted PC.
- Redirect on accept: on the accept edge, redirect_valid <= mispredict and redirect_pc <= actual next PC. redirect_valid is a one-cycle pulse and is 0 after any edge with no mispredicting accept. redirect_pc holds its last value otherwise.
- Drain FSM, states IDLE and ISSUE:
  - IDLE: command outputs 0. Go to ISSUE at the edge where FIFO is non-empty and upd_hold=0; the head is popped on that edge.
  - ISSUE: command outputs are driven for exactly one cycle from the popped entry:
    - hit=1: state_write=1, btb_write=0.
    - hit=0 & taken=1: btb_write=1, state_write=0.
    - hit=0 & taken=0: btb_write=0, state_write=0.
    - In all cases: branch_e=1, state_change=taken, branch_address_in=pc, predicted_address_in=target.
  - From ISSUE: if FIFO is non-empty (after the pop) and upd_hold=0, pop the next entry and stay in ISSUE (back-to-back, one update per cycle). Otherwise go to IDLE.
  - btb_write and state_write are never 1 in the same cycle.
- Latency: an entry accepted at edge N into an empty FIFO with upd_hold=0 is popped at edge N+1 and its command is visible in the cycle after edge N+1.
- upd_hold=1 blocks the pop at that edge. The FIFO keeps its contents, and accepts continue until full.
- Simultaneous push and pop on one edge: q_count is unchanged. Pointers wrap modulo QDEPTH.
- Ordering: strict FIFO. Updates reach the BTB in resolution order.
- Counters:
  - branch_count += 1 per accept.
  - mispredict_count += 1 per mispredicting accept.
  - Both saturate at all-ones.
  - clear_stats=1 zeroes both at the edge and takes priority over an increment in the same cycle.

Test Plan:
- Reset then single accept, pc=0x40, target=0x80, taken=1, hit=0 → redirect_valid pulse with redirect_pc=0x80 on the next cycle. One cycle later: btb_write=1, branch_e=1, state_change=1, branch_address_in=0x40, predicted_address_in=0x80. branch_count=1, mispredict_count=1.
- Accept pc=0x100, target=0x200, hit=1, res_pred_pc=0x200, taken=0 → redirect_pc=0x104 with redirect_valid=1. Drained command: state_write=1, state_change=0, btb_write=0.
- Correct prediction, hit=1, pred=0x200, taken=1, target=0x200 → redirect_valid stays 0, mispredict_count unchanged, state_write=1, state_change=1.
- upd_hold=1 with 5 back-to-back accepts (QDEPTH=4) → res_ready=0 once q_count=4; the 5th is held off. Release hold → 4 consecutive one-cycle commands in order, then the 5th is accepted and drained.
- Drop reset to 0 while q_count=3 and ISSUE is active → all outputs 0 immediately, q_count=0. After release no stale commands are issued.
- Preload branch_count to all-ones via 2^CNT_W accepts (CNT_W=4: 16 accepts, plus 1 more) → count stays at 15. clear_stats together with an accept → count=0.
